// File: rtl/ram_rmw_pkg.sv
// Shared types and constants for the RAM read-modify-write adapter.
package ram_rmw_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam logic [BE_W-1:0] BE_FULL = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RSP  = 2'd2
  } state_t;

endpackage

// File: rtl/rmw_byte_merge.sv
// Byte-lane merge: each lane comes from the new word when its enable is set,
// otherwise from the old word.
module rmw_byte_merge
  import ram_rmw_pkg::*;
(
  input  logic [WORD_W-1:0] i_old,
  input  logic [WORD_W-1:0] i_new,
  input  logic [BE_W-1:0]   i_be,
  output logic [WORD_W-1:0] o_merged
);

  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
    assign o_merged[gi*8 +: 8] = i_be[gi] ? i_new[gi*8 +: 8] : i_old[gi*8 +: 8];
  end

endmodule

// File: rtl/ram_rmw_adapter.sv
// Core load/store front end for a word-only RAM; partial stores are turned
// into a read-modify-write over the RAM's registered read port.
module ram_rmw_adapter
  import ram_rmw_pkg::*;
#(
  parameter int MEM_SIZE = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [BE_W-1:0]   req_be,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              ram_we,
  output logic [31:0]       ram_addr,
  output logic [WORD_W-1:0] ram_din,
  input  logic [WORD_W-1:0] ram_dout
);

  if (MEM_SIZE <= 0) begin : g_bad_mem_size
    $error("MEM_SIZE must be positive");
  end

  state_t              r_state;
  state_t              w_state_next;
  logic [31:2]         r_addr_q;
  logic                r_we_q;
  logic [BE_W-1:0]     r_be_q;
  logic [WORD_W-1:0]   r_wdata_q;
  logic [WORD_W-1:0]   r_rdata_q;
  logic [WORD_W-1:0]   w_rdata_next;
  logic                w_rdata_load;
  logic                w_accept;
  logic [WORD_W-1:0]   w_merged;
  logic                w_unused_addr_lsb;

  // Byte offset within the word has no meaning to a word RAM.
  assign w_unused_addr_lsb = ^req_addr[1:0];

  assign req_ready = (r_state == IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;
  assign rsp_valid = (r_state == RSP);
  assign rsp_rdata = r_rdata_q;

  rmw_byte_merge u_merge (
    .i_old    (ram_dout),
    .i_new    (r_wdata_q),
    .i_be     (r_be_q),
    .o_merged (w_merged)
  );

  always_comb begin
    w_state_next = r_state;
    w_rdata_load = 1'b0;
    w_rdata_next = r_rdata_q;
    ram_we       = 1'b0;
    ram_addr     = '0;
    ram_din      = '0;
    case (r_state)
      IDLE: begin
        ram_addr = {req_addr[31:2], 2'b00};
        if (w_accept) begin
          if (req_we && (req_be == BE_FULL)) begin
            ram_we       = 1'b1;
            ram_din      = req_wdata;
            w_rdata_load = 1'b1;
            w_rdata_next = '0;
            w_state_next = RSP;
          end else begin
            w_state_next = RD;
          end
        end
      end
      RD: begin
        ram_addr     = {r_addr_q, 2'b00};
        w_rdata_load = 1'b1;
        if (r_we_q) begin
          w_rdata_next = '0;
          if (r_be_q != '0) begin
            ram_we  = 1'b1;
            ram_din = w_merged;
          end
        end else begin
          w_rdata_next = ram_dout;
        end
        w_state_next = RSP;
      end
      RSP: begin
        ram_addr     = {r_addr_q, 2'b00};
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    // Reset is asynchronous, so the combinational RAM port must be quiet too.
    if (rst) begin
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_din  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr_q  <= '0;
      r_we_q    <= 1'b0;
      r_be_q    <= '0;
      r_wdata_q <= '0;
      r_rdata_q <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_addr_q  <= req_addr[31:2];
        r_we_q    <= req_we;
        r_be_q    <= req_be;
        r_wdata_q <= req_wdata;
      end
      // Only updated on entry to RSP so the response data holds afterwards.
      if (w_rdata_load) begin
        r_rdata_q <= w_rdata_next;
      end
    end
  end

endmodule

// File: tb/tb_ram_rmw_adapter.sv
// Directed bench for ram_rmw_adapter with a small registered-read word RAM.
module tb_ram_rmw_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  logic [31:0] mem [0:15];
  logic        preload;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_rmw_adapter #(.MEM_SIZE(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  always @(posedge clk) begin
    if (preload) begin
      mem[4] <= 32'h11223344;
      mem[5] <= 32'h55667788;
    end else if (ram_we) begin
      mem[ram_addr[5:2]] <= ram_din;
    end
    ram_dout <= mem[ram_addr[5:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_be = 4'hF; req_wdata = '0;
    mid;
    chk({tag, "_c0_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_c0_addr"}, ram_addr, {addr[31:2], 2'b00});
    next_cycle;
    req_valid = 1'b0;
    mid;
    chk({tag, "_c1_ready"}, {31'd0, req_ready}, 32'd0);
    chk({tag, "_c1_we"}, {31'd0, ram_we}, 32'd0);
    chk({tag, "_c1_rsp"}, {31'd0, rsp_valid}, 32'd0);
    next_cycle;
    mid;
    chk({tag, "_c2_rsp"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_c2_rdata"}, rsp_rdata, exp);
    chk({tag, "_c2_ready"}, {31'd0, req_ready}, 32'd0);
    next_cycle;
  endtask

  initial begin
    rst = 1'b1; preload = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0;
    repeat (2) next_cycle;
    preload = 1'b0;
    // Outputs stay zero under reset even with a live request on the inputs.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h14; req_be = 4'hF; req_wdata = 32'hCAFEF00D;
    mid;
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_we", {31'd0, ram_we}, 32'd0);
    chk("rst_addr", ram_addr, 32'd0);
    chk("rst_din", ram_din, 32'd0);
    chk("rst_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    next_cycle;
    rst = 1'b0; req_valid = 1'b0;
    mid;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    next_cycle;

    do_load("load13", 32'h13, 32'h11223344);
    mid;
    chk("hold_rdata", rsp_rdata, 32'h11223344);
    chk("hold_rsp", {31'd0, rsp_valid}, 32'd0);
    next_cycle;

    // Reset in cycle 1 of a partial store must drop it entirely.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_be = 4'b0001; req_wdata = 32'h000000FF;
    mid;
    chk("rmid_c0_ready", {31'd0, req_ready}, 32'd1);
    next_cycle;
    req_valid = 1'b0; rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mid;
      chk("rmid_we", {31'd0, ram_we}, 32'd0);
      chk("rmid_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("rmid_ready", {31'd0, req_ready}, 32'd0);
      chk("rmid_addr", ram_addr, 32'd0);
      chk("rmid_din", ram_din, 32'd0);
      chk("rmid_rdata", rsp_rdata, 32'd0);
      next_cycle;
    end
    rst = 1'b0;
    mid;
    chk("rmid_rel_ready", {31'd0, req_ready}, 32'd1);
    chk("rmid_rel_rsp", {31'd0, rsp_valid}, 32'd0);
    next_cycle;
    do_load("rmid_reload", 32'h10, 32'h11223344);

    // Byte store to lane 1.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_be = 4'b0010; req_wdata = 32'h0000AB00;
    mid;
    chk("bst_c0_we", {31'd0, ram_we}, 32'd0);
    chk("bst_c0_ready", {31'd0, req_ready}, 32'd1);
    next_cycle;
    req_valid = 1'b0;
    mid;
    chk("bst_c1_we", {31'd0, ram_we}, 32'd1);
    chk("bst_c1_din", ram_din, 32'h1122AB44);
    chk("bst_c1_addr", ram_addr, 32'h10);
    chk("bst_c1_rsp", {31'd0, rsp_valid}, 32'd0);
    next_cycle;
    mid;
    chk("bst_c2_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("bst_c2_rdata", rsp_rdata, 32'd0);
    chk("bst_c2_we", {31'd0, ram_we}, 32'd0);
    next_cycle;
    do_load("bst_reload", 32'h10, 32'h1122AB44);

    // Full-word store.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h14; req_be = 4'hF; req_wdata = 32'hDEADBEEF;
    mid;
    chk("fst_c0_we", {31'd0, ram_we}, 32'd1);
    chk("fst_c0_din", ram_din, 32'hDEADBEEF);
    chk("fst_c0_addr", ram_addr, 32'h14);
    next_cycle;
    req_valid = 1'b0;
    mid;
    chk("fst_c1_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("fst_c1_rdata", rsp_rdata, 32'd0);
    chk("fst_c1_we", {31'd0, ram_we}, 32'd0);
    chk("fst_c1_ready", {31'd0, req_ready}, 32'd0);
    next_cycle;
    mid;
    chk("fst_c2_ready", {31'd0, req_ready}, 32'd1);
    chk("fst_c2_rsp", {31'd0, rsp_valid}, 32'd0);
    next_cycle;
    do_load("fst_reload", 32'h14, 32'hDEADBEEF);

    // Empty store: no write at all.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h14; req_be = 4'h0; req_wdata = 32'h12345678;
    mid;
    chk("est_c0_we", {31'd0, ram_we}, 32'd0);
    next_cycle;
    req_valid = 1'b0;
    mid;
    chk("est_c1_we", {31'd0, ram_we}, 32'd0);
    chk("est_c1_rsp", {31'd0, rsp_valid}, 32'd0);
    next_cycle;
    mid;
    chk("est_c2_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("est_c2_rdata", rsp_rdata, 32'd0);
    chk("est_c2_we", {31'd0, ram_we}, 32'd0);
    next_cycle;
    do_load("est_reload", 32'h14, 32'hDEADBEEF);

    // Back-to-back loads with req_valid held high.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'hF; req_wdata = '0;
    mid;
    chk("b2b_c0_ready", {31'd0, req_ready}, 32'd1);
    chk("b2b_c0_addr", ram_addr, 32'h10);
    next_cycle;
    req_addr = 32'h14;
    mid;
    chk("b2b_c1_ready", {31'd0, req_ready}, 32'd0);
    next_cycle;
    mid;
    chk("b2b_c2_ready", {31'd0, req_ready}, 32'd0);
    chk("b2b_c2_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_c2_rdata", rsp_rdata, 32'h1122AB44);
    next_cycle;
    mid;
    chk("b2b_c3_ready", {31'd0, req_ready}, 32'd1);
    chk("b2b_c3_addr", ram_addr, 32'h14);
    chk("b2b_c3_rsp", {31'd0, rsp_valid}, 32'd0);
    next_cycle;
    req_valid = 1'b0;
    mid;
    chk("b2b_c4_ready", {31'd0, req_ready}, 32'd0);
    next_cycle;
    mid;
    chk("b2b_c5_ready", {31'd0, req_ready}, 32'd0);
    chk("b2b_c5_rsp", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_c5_rdata", rsp_rdata, 32'hDEADBEEF);
    next_cycle;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_rmw_adapter.md
# ram_rmw_adapter

Request-side front end for the single-port 32-bit word RAM model in the testbench memory subsystem. It takes core load/store requests with byte enables and turns them into word accesses on the RAM port. The RAM has no byte-write capability, so partial stores become a read-modify-write sequence. It sits directly upstream of the RAM: it drives the RAM's write enable, address and write data, and consumes its registered read data.

## Interface
- `MEM_SIZE`, default 4096: RAM depth in words. Informational only; the adapter does no address range check.
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  1  core request valid
- `req_ready`  out  1  adapter accepts a request this cycle
- `req_we`  in  1  1 = store, 0 = load
- `req_addr`  in  32  byte address; bits [1:0] are ignored
- `req_be`  in  4  byte enables; bit i selects data byte i
- `req_wdata`  in  32  store data, byte-lane aligned
- `rsp_valid`  out  1  one-cycle response pulse
- `rsp_rdata`  out  32  load data; 0 for stores
- `ram_we`  out  1  RAM write enable
- `ram_addr`  out  32  RAM byte address, bits [1:0] forced to 0
- `ram_din`  out  32  RAM write data
- `ram_dout`  in  32  RAM read data, registered, one cycle after the address is presented

## Operation
- **State machine.** States are IDLE, RD and RSP.
- **Handshake.**
  - `req_ready` = (state == IDLE) and not `rst`.
  - A request is accepted on a cycle with `req_valid` and `req_ready` both high.
  - On acceptance, addr, we, be and wdata are latched into `*_q` registers.
- **IDLE.** `ram_addr` = {`req_addr`[31:2], 2'b00}, driven combinationally. Transitions on acceptance:
  - Load → RD.
  - Store with be == 4'hF → `ram_we`=1 and `ram_din`=`req_wdata` in the same cycle, then → RSP.
  - Store with be != 4'hF → RD. This includes be == 0.
- **RD.** `ram_addr` = `addr_q`.
  - Load: `rdata_q` <= `ram_dout`.
  - Store with be_q != 0: `ram_we`=1 and `ram_din`=merge(`ram_dout`, `wdata_q`, `be_q`). Byte i comes from `wdata_q` when `be_q`[i] is set, otherwise from `ram_dout`. `rdata_q` <= 0.
  - Store with be_q == 0: no write. `rdata_q` <= 0.
  - Always → RSP.
- **RSP.**
  - `rsp_valid`=1 and `rsp_rdata`=`rdata_q`. For a full-word store, `rdata_q` is cleared on acceptance.
  - Then → IDLE.
  - The response has no backpressure; the core must take it.
- **Outside RSP.** `rsp_valid`=0, and `rsp_rdata` holds its last value.
- **Write enable.** `ram_we` is high only in the two cases above and is never high in RSP.
- **Reset.**
  - While `rst` is high: state = IDLE, `rdata_q`=0, `rsp_valid`=0, `rsp_rdata`=0, `ram_we`=0, `ram_addr`=0, `ram_din`=0, `req_ready`=0.
  - A reset taken mid-sequence drops the request: no `ram_we` pulse and no response.

## Timing
- Cycle 0 is the accept cycle.
- **Load:** RAM address is presented in cycle 0, data is captured in cycle 1, `rsp_valid` is high in cycle 2.
- **Partial store:** `ram_we` is high in cycle 1, `rsp_valid` in cycle 2.
- **Full-word store:** `ram_we` is high in cycle 0, `rsp_valid` in cycle 1.
- **Throughput:** one load or partial store per 3 cycles, one full-word store per 2 cycles. The next acceptance is possible in the cycle after RSP.
- **Pass-through:** `req_*` inputs in IDLE reach `ram_addr`, `ram_we` and `ram_din` combinationally. Everything else is registered.

## Structure
- **Package `ram_rmw_pkg`:**
  - state enum (IDLE, RD, RSP)
  - `BE_FULL` = 4'hF
  - `WORD_W` = 32
  - `BE_W` = 4
- **Sub-module `rmw_byte_merge`:** combinational. Inputs old[31:0], new[31:0], be[3:0]; output merged[31:0]. It is instantiated once and used on the RD-state write path.
- **Top level:** the FSM, request latches and output muxing.

## Test plan
RAM is preloaded with word index 4 (byte 0x10) = 0x11223344 and word index 5 (byte 0x14) = 0x55667788.
- **Load.** Load at 0x13 → `ram_addr`=0x10 in cycle 0; `rsp_valid` in cycle 2 with `rsp_rdata`=0x11223344; `req_ready` low in cycles 1–2.
- **Byte store.** Store at 0x10, be=4'b0010, wdata=0x0000AB00 → cycle 1: `ram_we`=1, `ram_din`=0x1122AB44; cycle 2: `rsp_valid` with `rsp_rdata`=0. A following load at 0x10 returns 0x1122AB44.
- **Full-word store.** Store at 0x14, be=4'hF, wdata=0xDEADBEEF → cycle 0: `ram_we`=1; cycle 1: `rsp_valid`. A following load at 0x14 returns 0xDEADBEEF.
- **Empty store.** Store with be=0 at 0x14 → `ram_we` never asserts; `rsp_valid` in cycle 2; the word is unchanged.
- **Reset mid-operation.**
  - Setup: assert `rst` in cycle 1 of a partial store to 0x10.
  - While `rst` is high: `ram_we`=0, no `rsp_valid`, `req_ready`=0, and all outputs are 0.
  - After release: the word still reads 0x11223344 and `req_ready`=1.
- **Back-to-back loads.** `req_valid` held high for loads at 0x10 then 0x14 → acceptance in cycles 0 and 3; responses in cycles 2 and 5 with the correct data; `req_ready` pattern 1,0,0,1,0,0.
